octree_mem_arbiter: RTL and testbench

Shares the octree node SRAM between the searcher and the updater under the mode chosen by the octree controller's `mem_select`. Each requester issues single-beat read or write transactions over a valid/ready port. The arbiter grants ownership, drives a registered single-port SRAM interface and routes read data back to the issuing requester through a tagged response pipeline. It drains in-flight reads before ownership changes on a mode switch.

---
 rtl/octree_pkg.sv | 23 ++
 rtl/octree_rsp_router.sv | 59 +++++
 rtl/octree_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_octree_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/octree_pkg.sv
// Shared octree encodings: controller memory modes, SRAM owner and
// arbiter state.
package octree_pkg;

    localparam logic [1:0] MEM_NAN      = 2'd0;
    localparam logic [1:0] MEM_SEARCHER = 2'd1;
    localparam logic [1:0] MEM_UPDATER  = 2'd2;
    localparam logic [1:0] MEM_SHARED   = 2'd3;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_S    = 2'd1,
        OWNER_U    = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_S = 2'd1,
        OWN_U = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/octree_rsp_router.sv
// Tagged read-response pipeline: follows each read through the SRAM
// latency and hands the data back to the requester that issued it.
import octree_pkg::*;

module octree_rsp_router #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_accept,
    input  owner_e                rd_owner,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  s_rsp_valid,
    output logic [DATA_WIDTH-1:0] s_rsp_rdata,
    output logic                  u_rsp_valid,
    output logic [DATA_WIDTH-1:0] u_rsp_rdata,
    output logic [1:0]            inflight
);

    logic   t1_valid;
    logic   t2_valid;
    owner_e t1_owner;
    owner_e t2_owner;
    logic   hit_s;
    logic   hit_u;

    assign hit_s = t2_valid && (t2_owner == OWNER_S);
    assign hit_u = t2_valid && (t2_owner == OWNER_U);

    always_ff @(posedge clk) begin
        if (rst) begin
            t1_valid    <= 1'b0;
            t2_valid    <= 1'b0;
            t1_owner    <= OWNER_NONE;
            t2_owner    <= OWNER_NONE;
            s_rsp_valid <= 1'b0;
            u_rsp_valid <= 1'b0;
            s_rsp_rdata <= '0;
            u_rsp_rdata <= '0;
            inflight    <= 2'd0;
        end else begin
            t1_valid    <= rd_accept;
            t1_owner    <= rd_owner;
            t2_valid    <= t1_valid;
            t2_owner    <= t1_owner;
            s_rsp_valid <= hit_s;
            u_rsp_valid <= hit_u;
            if (hit_s) s_rsp_rdata <= sram_rdata;
            if (hit_u) u_rsp_rdata <= sram_rdata;
            // A read leaves the count when its response is registered
            case ({rd_accept, t2_valid})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: rtl/octree_mem_arbiter.sv
// Grants the octree node SRAM to the searcher or updater according to the
// controller mode, and drains outstanding reads before ownership moves.
import octree_pkg::*;

module octree_mem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 64,
    parameter int SELECT_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SELECT_WIDTH-1:0] mem_select,
    input  logic                    s_req_valid,
    input  logic                    s_req_we,
    input  logic                    s_req_lock,
    input  logic [ADDR_WIDTH-1:0]   s_req_addr,
    input  logic [DATA_WIDTH-1:0]   s_req_wdata,
    output logic                    s_req_ready,
    output logic                    s_rsp_valid,
    output logic [DATA_WIDTH-1:0]   s_rsp_rdata,
    input  logic                    u_req_valid,
    input  logic                    u_req_we,
    input  logic                    u_req_lock,
    input  logic [ADDR_WIDTH-1:0]   u_req_addr,
    input  logic [DATA_WIDTH-1:0]   u_req_wdata,
    output logic                    u_req_ready,
    output logic                    u_rsp_valid,
    output logic [DATA_WIDTH-1:0]   u_rsp_rdata,
    output logic                    sram_ce,
    output logic                    sram_we,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata,
    output logic [1:0]              owner,
    output logic                    busy
);

    arb_state_e state;
    logic       rr_ptr;
    logic       lock_held;
    logic [1:0] mode;
    logic       permit_s;
    logic       permit_u;
    logic       s_acc;
    logic       u_acc;
    logic       rd_accept;
    owner_e     rd_owner;
    logic [1:0] inflight;

    assign mode     = mem_select[1:0];
    assign permit_s = (mode == MEM_SEARCHER) || (mode == MEM_SHARED);
    assign permit_u = (mode == MEM_UPDATER) || (mode == MEM_SHARED);

    assign s_req_ready = (state == OWN_S) && permit_s;
    assign u_req_ready = (state == OWN_U) && permit_u;
    assign s_acc       = s_req_valid && s_req_ready;
    assign u_acc       = u_req_valid && u_req_ready;

    assign owner = (state == OWN_S) ? OWNER_S :
                   (state == OWN_U) ? OWNER_U : OWNER_NONE;
    assign busy  = (state != IDLE) || (inflight != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            lock_held <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mode == MEM_SEARCHER && s_req_valid) begin
                        state <= OWN_S;
                    end else if (mode == MEM_UPDATER && u_req_valid) begin
                        state <= OWN_U;
                    end else if (mode == MEM_SHARED && (s_req_valid || u_req_valid)) begin
                        // rr_ptr always ends up pointing at the loser
                        if (s_req_valid && (!u_req_valid || !rr_ptr)) begin
                            state  <= OWN_S;
                            rr_ptr <= 1'b1;
                        end else begin
                            state  <= OWN_U;
                            rr_ptr <= 1'b0;
                        end
                    end
                end
                OWN_S: begin
                    if (!permit_s) begin
                        state     <= (inflight != 2'd0) ? DRAIN : IDLE;
                        lock_held <= 1'b0;
                    end else if (s_acc && s_req_lock) begin
                        lock_held <= 1'b1;
                    end else if (s_acc && mode == MEM_SHARED && u_req_valid) begin
                        state     <= OWN_U;
                        rr_ptr    <= 1'b0;
                        lock_held <= 1'b0;
                    end else if (!s_acc && !lock_held) begin
                        state <= IDLE;
                    end else if (s_acc) begin
                        lock_held <= 1'b0;
                    end
                end
                OWN_U: begin
                    if (!permit_u) begin
                        state     <= (inflight != 2'd0) ? DRAIN : IDLE;
                        lock_held <= 1'b0;
                    end else if (u_acc && u_req_lock) begin
                        lock_held <= 1'b1;
                    end else if (u_acc && mode == MEM_SHARED && s_req_valid) begin
                        state     <= OWN_S;
                        rr_ptr    <= 1'b1;
                        lock_held <= 1'b0;
                    end else if (!u_acc && !lock_held) begin
                        state <= IDLE;
                    end else if (u_acc) begin
                        lock_held <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (inflight == 2'd0) state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_ce <= s_acc || u_acc;
            sram_we <= (s_acc && s_req_we) || (u_acc && u_req_we);
            if (s_acc) begin
                sram_addr  <= s_req_addr;
                sram_wdata <= s_req_wdata;
            end else if (u_acc) begin
                sram_addr  <= u_req_addr;
                sram_wdata <= u_req_wdata;
            end
        end
    end

    assign rd_accept = (s_acc && !s_req_we) || (u_acc && !u_req_we);
    assign rd_owner  = s_acc ? OWNER_S : OWNER_U;

    octree_rsp_router #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_router (
        .clk        (clk),
        .rst        (rst),
        .rd_accept  (rd_accept),
        .rd_owner   (rd_owner),
        .sram_rdata (sram_rdata),
        .s_rsp_valid(s_rsp_valid),
        .s_rsp_rdata(s_rsp_rdata),
        .u_rsp_valid(u_rsp_valid),
        .u_rsp_rdata(u_rsp_rdata),
        .inflight   (inflight)
    );

endmodule

// File: tb/tb_octree_mem_arbiter.sv
// Directed bench for octree_mem_arbiter with a behavioural one-cycle
// SRAM attached to the registered command port.
module tb_octree_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mem_select;
    logic        s_req_valid, s_req_we, s_req_lock;
    logic [11:0] s_req_addr;
    logic [63:0] s_req_wdata;
    logic        s_req_ready, s_rsp_valid;
    logic [63:0] s_rsp_rdata;
    logic        u_req_valid, u_req_we, u_req_lock;
    logic [11:0] u_req_addr;
    logic [63:0] u_req_wdata;
    logic        u_req_ready, u_rsp_valid;
    logic [63:0] u_rsp_rdata;
    logic        sram_ce, sram_we;
    logic [11:0] sram_addr;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata = '0;
    logic [1:0]  owner;
    logic        busy;

    logic [63:0] mem [0:4095];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    octree_mem_arbiter dut (
        .clk(clk), .rst(rst), .mem_select(mem_select),
        .s_req_valid(s_req_valid), .s_req_we(s_req_we),
        .s_req_lock(s_req_lock), .s_req_addr(s_req_addr),
        .s_req_wdata(s_req_wdata), .s_req_ready(s_req_ready),
        .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
        .u_req_valid(u_req_valid), .u_req_we(u_req_we),
        .u_req_lock(u_req_lock), .u_req_addr(u_req_addr),
        .u_req_wdata(u_req_wdata), .u_req_ready(u_req_ready),
        .u_rsp_valid(u_rsp_valid), .u_rsp_rdata(u_rsp_rdata),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .owner(owner), .busy(busy)
    );

    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr];
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_select = 2'd0;
        s_req_valid = 0; s_req_we = 0; s_req_lock = 0; s_req_addr = '0; s_req_wdata = '0;
        u_req_valid = 0; u_req_we = 0; u_req_lock = 0; u_req_addr = '0; u_req_wdata = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"}, 64'({s_req_ready, u_req_ready, s_rsp_valid, u_rsp_valid,
                                sram_ce, sram_we, owner, busy}), 64'h0);
        chk({tag, "_addr"}, 64'(sram_addr), 64'h0);
        chk({tag, "_wdata"}, sram_wdata, 64'h0);
        chk({tag, "_s_rdata"}, s_rsp_rdata, 64'h0);
        chk({tag, "_u_rdata"}, u_rsp_rdata, 64'h0);
    endtask

    initial begin
        // Mode 1: write then read back through the searcher
        do_reset();
        mid();
        check_reset("rst");
        mem_select = 2'd1;
        s_req_valid = 1; s_req_we = 1; s_req_addr = 12'h010; s_req_wdata = 64'hA5A5;
        cyc();
        mid();
        chk("m1_grant_ready", 64'(s_req_ready), 64'd1);
        chk("m1_grant_owner", 64'(owner), 64'd1);
        cyc();
        s_req_we = 0;
        mid();
        chk("m1_wr_cmd", 64'({sram_ce, sram_we}), 64'b11);
        chk("m1_wr_addr", 64'(sram_addr), 64'h010);
        chk("m1_wr_data", sram_wdata, 64'hA5A5);
        cyc();
        s_req_valid = 0;
        mid();
        chk("m1_rd_cmd", 64'({sram_ce, sram_we}), 64'b10);
        cyc();
        mid();
        chk("m1_rsp_early", 64'(s_rsp_valid), 64'd0);
        chk("m1_idle_owner", 64'(owner), 64'd0);
        chk("m1_ce_off", 64'(sram_ce), 64'd0);
        cyc();
        mid();
        chk("m1_rsp_valid", 64'(s_rsp_valid), 64'd1);
        chk("m1_rsp_data", s_rsp_rdata, 64'hA5A5);
        chk("m1_u_rsp_quiet", 64'(u_rsp_valid), 64'd0);
        cyc();
        mid();
        chk("m1_rsp_pulse", 64'(s_rsp_valid), 64'd0);

        // Mode 3: continuous contention alternates without bubbles
        do_reset();
        mem_select = 2'd3;
        s_req_valid = 1; s_req_we = 1; s_req_addr = 12'h100; s_req_wdata = 64'd1;
        u_req_valid = 1; u_req_we = 1; u_req_addr = 12'h200; u_req_wdata = 64'd2;
        cyc();
        mid();
        chk("rr_first_owner", 64'(owner), 64'd1);
        chk("rr_first_ready", 64'({s_req_ready, u_req_ready}), 64'b10);
        for (int i = 0; i < 4; i++) begin
            cyc();
            mid();
            chk("rr_owner", 64'(owner), (i % 2 == 0) ? 64'd2 : 64'd1);
            chk("rr_ce", 64'(sram_ce), 64'd1);
            chk("rr_addr", 64'(sram_addr), (i % 2 == 0) ? 64'h100 : 64'h200);
        end
        s_req_valid = 0; u_req_valid = 0;

        // Mode 3: searcher lock holds off the updater for three beats
        do_reset();
        mem_select = 2'd3;
        s_req_valid = 1; s_req_we = 1; s_req_lock = 1; s_req_addr = 12'h300;
        u_req_valid = 1; u_req_we = 1; u_req_addr = 12'h301;
        cyc();
        for (int i = 0; i < 3; i++) begin
            s_req_lock = (i < 2);
            mid();
            chk("lock_owner", 64'(owner), 64'd1);
            chk("lock_u_ready", 64'(u_req_ready), 64'd0);
            cyc();
        end
        mid();
        chk("lock_release", 64'({owner, s_req_ready, u_req_ready}), 64'b1001);
        s_req_valid = 0; u_req_valid = 0; s_req_lock = 0;

        // Mode 1 -> 2 with two reads in flight drains first
        do_reset();
        mem_select = 2'd1;
        s_req_valid = 1; s_req_we = 0; s_req_addr = 12'h020;
        cyc();
        cyc();
        s_req_addr = 12'h021;
        cyc();
        mem_select = 2'd2;
        s_req_valid = 0;
        u_req_valid = 1; u_req_we = 1; u_req_addr = 12'h040;
        mid();
        chk("sw_ready_off", 64'({s_req_ready, u_req_ready}), 64'b00);
        chk("sw_owner_still_s", 64'(owner), 64'd1);
        cyc();
        mid();
        chk("drain1", 64'({owner, busy, u_req_ready, s_rsp_valid}), 64'b00101);
        chk("drain1_data", s_rsp_rdata, 64'hC0DE_0000_0000_0020);
        cyc();
        mid();
        chk("drain2", 64'({owner, busy, u_req_ready, s_rsp_valid}), 64'b00101);
        chk("drain2_data", s_rsp_rdata, 64'hC0DE_0000_0000_0021);
        cyc();
        mid();
        chk("sw_idle", 64'({owner, busy, u_req_ready, s_rsp_valid}), 64'b00000);
        cyc();
        mid();
        chk("sw_u_grant", 64'({owner, u_req_ready}), 64'b101);
        u_req_valid = 0;

        // Mode 0 never grants
        do_reset();
        mem_select = 2'd0;
        s_req_valid = 1; u_req_valid = 1;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("nan_quiet", 64'({s_req_ready, u_req_ready, sram_ce, busy}), 64'h0);
            cyc();
        end
        s_req_valid = 0; u_req_valid = 0;

        // Reset right after a read accept drops the response
        do_reset();
        mem_select = 2'd1;
        s_req_valid = 1; s_req_we = 0; s_req_addr = 12'h030;
        cyc();
        cyc();
        rst = 1;
        s_req_valid = 0;
        mid();
        chk("rstmid_cmd", 64'({sram_ce, sram_we}), 64'b10);
        cyc();
        rst = 0;
        mid();
        check_reset("rstmid");
        for (int i = 0; i < 4; i++) begin
            cyc();
            mid();
            chk("rstmid_no_rsp", 64'({s_rsp_valid, u_rsp_valid}), 64'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
